// File: rtl/snitch_icache_sched_pkg.sv
// Shared types and helpers for the instruction-cache RAM scheduler.
//   sched_state_e : SWEEP (invalidating all lines) / RUN (arbitrating users)
//   ram_wsel_e    : RAM write source select
//   way_onehot()  : decodes a way index to a per-way enable vector
package snitch_icache_sched_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } sched_state_e;

    typedef enum logic {
        WSEL_ZERO   = 1'b0,
        WSEL_REFILL = 1'b1
    } ram_wsel_e;

    // Widest way vector the decode helper can produce; callers slice it.
    localparam int unsigned MAX_WAYS = 64;

    // A direct-mapped cache (single way) always enables its only way.
    function automatic logic [MAX_WAYS-1:0] way_onehot(input int unsigned way,
                                                       input int unsigned count);
        logic [MAX_WAYS-1:0] oh;
        if (count <= 1) oh = '1;
        else            oh = MAX_WAYS'(1) << way;
        return oh;
    endfunction

endpackage

// File: rtl/snitch_icache_ram_sched_if.sv
// Request and RAM-side signal bundle of the instruction-cache RAM scheduler.
//   slave  : the scheduler (takes flush/lookup/refill requests, drives RAM)
//   master : the surrounding lookup stage / testbench
// Signals: flush/lookup/write handshakes, lookup_out_ready_i, RAM request,
// write enable, address, write select, read-valid strobe, busy and the two
// performance counters (zero unless SNITCH_ICACHE_SCHED_PERF_EN is defined).
interface snitch_icache_ram_sched_if #(
    parameter int unsigned LINE_COUNT = 128,
    parameter int unsigned WAY_COUNT  = 4
);
    localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT);
    localparam int unsigned WAY_ALIGN   = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1;

    logic                   flush_valid_i;
    logic                   flush_ready_o;
    logic                   lookup_valid_i;
    logic [COUNT_ALIGN-1:0] lookup_addr_i;
    logic                   lookup_ready_o;
    logic                   lookup_out_ready_i;
    logic                   write_valid_i;
    logic [COUNT_ALIGN-1:0] write_addr_i;
    logic [WAY_ALIGN-1:0]   write_way_i;
    logic                   write_ready_o;
    logic [WAY_COUNT-1:0]   ram_req_o;
    logic                   ram_we_o;
    logic [COUNT_ALIGN-1:0] ram_addr_o;
    logic                   ram_wsel_o;
    logic                   ram_rvalid_o;
    logic                   busy_o;
    logic [31:0]            perf_wr_stall_o;
    logic [31:0]            perf_lk_stall_o;

    modport slave (
        input  flush_valid_i, lookup_valid_i, lookup_addr_i, lookup_out_ready_i,
               write_valid_i, write_addr_i, write_way_i,
        output flush_ready_o, lookup_ready_o, write_ready_o, ram_req_o, ram_we_o,
               ram_addr_o, ram_wsel_o, ram_rvalid_o, busy_o,
               perf_wr_stall_o, perf_lk_stall_o
    );

    modport master (
        output flush_valid_i, lookup_valid_i, lookup_addr_i, lookup_out_ready_i,
               write_valid_i, write_addr_i, write_way_i,
        input  flush_ready_o, lookup_ready_o, write_ready_o, ram_req_o, ram_we_o,
               ram_addr_o, ram_wsel_o, ram_rvalid_o, busy_o,
               perf_wr_stall_o, perf_lk_stall_o
    );
endinterface

// File: rtl/snitch_icache_sched_sweep.sv
// Invalidation sweep line counter.
//   clk_i, rst_i : clock, synchronous active-high reset (clears the count)
//   start_i      : restart the sweep from line 0
//   en_i         : advance one line this cycle
//   cnt_o        : line currently being invalidated
//   done_o       : last line is being invalidated this cycle
module snitch_icache_sched_sweep #(
    parameter int unsigned LINE_COUNT = 128,
    localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   en_i,
    output logic [COUNT_ALIGN-1:0] cnt_o,
    output logic                   done_o
);
    logic [COUNT_ALIGN-1:0] cnt_q, cnt_d;

    assign done_o = en_i && (cnt_q == COUNT_ALIGN'(LINE_COUNT - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i)     cnt_d = '0;
        else if (done_o) cnt_d = '0;
        else if (en_i)   cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/snitch_icache_ram_sched.sv
// Shares the single-port tag/data RAM ways of the icache lookup stage between
// the invalidation sweep (highest priority), refill writes and lookup reads.
// Refills beat lookups, but after MAX_WR_BURST back-to-back refill grants a
// waiting lookup gets one slot.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : request handshakes and RAM controls, see the interface
// Optional macro SNITCH_ICACHE_SCHED_PERF_EN builds the saturating stall
// counters; otherwise the perf outputs are tied to zero.
module snitch_icache_ram_sched
    import snitch_icache_sched_pkg::*;
#(
    parameter int unsigned LINE_COUNT   = 128,
    parameter int unsigned WAY_COUNT    = 4,
    parameter int unsigned MAX_WR_BURST = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    snitch_icache_ram_sched_if.slave bus
);
    localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT);
    localparam int unsigned WAY_ALIGN   = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1;
    localparam int unsigned BURST_W     = $clog2(MAX_WR_BURST + 1);

    sched_state_e           state_q, state_d;
    logic [BURST_W-1:0]     burst_q, burst_d;
    logic                   rvalid_q, rvalid_d;
    logic                   run, lk_pend, wr_gnt, rd_gnt, flush_hs;
    logic                   sweep_en, sweep_done;
    logic [COUNT_ALIGN-1:0] sweep_cnt;
    logic [WAY_ALIGN-1:0]   wr_way;
    logic [MAX_WAYS-1:0]    way_oh;

    logic [WAY_COUNT-1:0]   ram_req;
    logic                   ram_we, flush_rdy;
    logic [COUNT_ALIGN-1:0] ram_addr;
    ram_wsel_e              ram_wsel;

    assign wr_way   = bus.write_way_i;
    assign way_oh   = way_onehot(32'(wr_way), WAY_COUNT);
    assign run      = (state_q == RUN) && !rst_i;
    assign sweep_en = (state_q == SWEEP) && !rst_i;
    assign lk_pend  = bus.lookup_valid_i & bus.lookup_out_ready_i;
    assign wr_gnt   = run & bus.write_valid_i & (!lk_pend | (burst_q < BURST_W'(MAX_WR_BURST)));
    assign rd_gnt   = run & !wr_gnt & lk_pend;
    assign flush_hs = run & bus.flush_valid_i;

    snitch_icache_sched_sweep #(.LINE_COUNT(LINE_COUNT)) i_sweep (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (flush_hs),
        .en_i    (sweep_en),
        .cnt_o   (sweep_cnt),
        .done_o  (sweep_done)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= SWEEP;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SWEEP:   if (sweep_done) state_d = RUN;
            RUN:     if (flush_hs)   state_d = SWEEP;
            default: state_d = SWEEP;
        endcase
    end

    // Output logic; everything RAM- and ready-facing is held low in reset.
    always_comb begin
        ram_req   = '0;
        ram_we    = 1'b0;
        ram_addr  = bus.lookup_addr_i;
        ram_wsel  = WSEL_REFILL;
        flush_rdy = 1'b0;
        if (rst_i) begin
            ram_addr = '0;
            ram_wsel = WSEL_ZERO;
        end else if (state_q == SWEEP) begin
            ram_req  = '1;
            ram_we   = 1'b1;
            ram_wsel = WSEL_ZERO;
            ram_addr = sweep_cnt;
        end else begin
            flush_rdy = 1'b1;
            if (wr_gnt) begin
                ram_req  = way_oh[WAY_COUNT-1:0];
                ram_we   = 1'b1;
                ram_addr = bus.write_addr_i;
            end else if (rd_gnt) begin
                ram_req  = '1;
            end
        end
    end

    // Refill burst limiter: a read grant or an absent refill restarts the
    // budget; the count saturates so a long lookup-free refill run does not
    // wrap and re-starve the next lookup.
    always_comb begin
        burst_d = burst_q;
        if (wr_gnt) begin
            if (burst_q < BURST_W'(MAX_WR_BURST)) burst_d = burst_q + 1'b1;
        end else if (rd_gnt || !bus.write_valid_i) begin
            burst_d = '0;
        end
        rvalid_d = rd_gnt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            burst_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            burst_q  <= burst_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.ram_req_o      = ram_req;
    assign bus.ram_we_o       = ram_we;
    assign bus.ram_addr_o     = ram_addr;
    assign bus.ram_wsel_o     = ram_wsel;
    assign bus.ram_rvalid_o   = rvalid_q & !rst_i;
    assign bus.flush_ready_o  = flush_rdy;
    assign bus.write_ready_o  = wr_gnt;
    assign bus.lookup_ready_o = rd_gnt;
    assign bus.busy_o         = (state_q == SWEEP);

`ifdef SNITCH_ICACHE_SCHED_PERF_EN
    logic [31:0] perf_wr_q, perf_wr_d, perf_lk_q, perf_lk_d;

    always_comb begin
        perf_wr_d = perf_wr_q;
        perf_lk_d = perf_lk_q;
        if (bus.write_valid_i && !wr_gnt && (perf_wr_q != '1))  perf_wr_d = perf_wr_q + 1'b1;
        if (bus.lookup_valid_i && !rd_gnt && (perf_lk_q != '1)) perf_lk_d = perf_lk_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_wr_q <= '0;
            perf_lk_q <= '0;
        end else begin
            perf_wr_q <= perf_wr_d;
            perf_lk_q <= perf_lk_d;
        end
    end

    assign bus.perf_wr_stall_o = perf_wr_q;
    assign bus.perf_lk_stall_o = perf_lk_q;
`else
    assign bus.perf_wr_stall_o = '0;
    assign bus.perf_lk_stall_o = '0;
`endif
endmodule

// File: tb/tb_snitch_icache_ram_sched.sv
// Directed scoreboard bench for snitch_icache_ram_sched (128 lines, 4 ways,
// burst limit 4). The driver sets inputs just after each rising edge and
// queues the hand-derived expected outputs for that cycle; the monitor pops
// and compares on the falling edge.
module tb_snitch_icache_ram_sched;

    typedef struct {
        string      tag;
        logic [3:0] req;
        logic       we;
        logic [6:0] addr;
        logic       wsel;
        logic       fl;
        logic       wr;
        logic       lk;
        logic       busy;
        logic       chk_busy;
        logic       rv;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    snitch_icache_ram_sched_if #(.LINE_COUNT(128), .WAY_COUNT(4)) bus ();

    snitch_icache_ram_sched #(
        .LINE_COUNT   (128),
        .WAY_COUNT    (4),
        .MAX_WR_BURST (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [3:0] req, input logic we,
                                input logic [6:0] addr, input logic wsel, input logic fl,
                                input logic wr, input logic lk, input logic busy,
                                input logic chk_busy, input logic rv);
        exp_t e;
        e.tag = tag; e.req = req; e.we = we; e.addr = addr; e.wsel = wsel;
        e.fl = fl; e.wr = wr; e.lk = lk; e.busy = busy; e.chk_busy = chk_busy; e.rv = rv;
        return e;
    endfunction

    function automatic exp_t e_rst(input string tag);
        return mk(tag, 4'h0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic exp_t e_sweep(input string tag, input int i);
        return mk(tag, 4'hF, 1'b1, 7'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endfunction
    function automatic exp_t e_w(input string tag, input logic [3:0] oh, input logic [6:0] a, input logic rv);
        return mk(tag, oh, 1'b1, a, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, rv);
    endfunction
    function automatic exp_t e_r(input string tag, input logic [6:0] a, input logic rv);
        return mk(tag, 4'hF, 1'b0, a, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, rv);
    endfunction
    function automatic exp_t e_idle(input string tag, input logic [6:0] a, input logic rv);
        return mk(tag, 4'h0, 1'b0, a, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rv);
    endfunction

    // Monitor: one expected record per cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, ".req"},    32'(bus.ram_req_o),      32'(e.req));
            if (e.req != 4'h0)
                chk({e.tag, ".we"}, 32'(bus.ram_we_o),       32'(e.we));
            chk({e.tag, ".addr"},   32'(bus.ram_addr_o),     32'(e.addr));
            chk({e.tag, ".wsel"},   32'(bus.ram_wsel_o),     32'(e.wsel));
            chk({e.tag, ".fl_rdy"}, 32'(bus.flush_ready_o),  32'(e.fl));
            chk({e.tag, ".wr_rdy"}, 32'(bus.write_ready_o),  32'(e.wr));
            chk({e.tag, ".lk_rdy"}, 32'(bus.lookup_ready_o), 32'(e.lk));
            chk({e.tag, ".rvalid"}, 32'(bus.ram_rvalid_o),   32'(e.rv));
            if (e.chk_busy)
                chk({e.tag, ".busy"}, 32'(bus.busy_o),       32'(e.busy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic prev_r;
        rst = 1'b1;
        bus.flush_valid_i = 1'b0;
        bus.lookup_valid_i = 1'b0;
        bus.lookup_addr_i = '0;
        bus.lookup_out_ready_i = 1'b0;
        bus.write_valid_i = 1'b0;
        bus.write_addr_i = '0;
        bus.write_way_i = '0;

        // Reset with every request raised: nothing may be granted.
        for (int i = 0; i < 2; i++) begin
            tick();
            rst = 1'b1;
            bus.flush_valid_i = 1'b1; bus.write_valid_i = 1'b1;
            bus.lookup_valid_i = 1'b1; bus.lookup_out_ready_i = 1'b1;
            q.push_back(e_rst("rst"));
        end

        // Post-reset sweep with refill and lookup both waiting.
        for (int i = 0; i < 128; i++) begin
            tick();
            if (i == 0) begin
                rst = 1'b0; bus.flush_valid_i = 1'b0;
                bus.write_valid_i = 1'b1; bus.write_addr_i = 7'h05; bus.write_way_i = 2'd1;
                bus.lookup_valid_i = 1'b1; bus.lookup_addr_i = 7'h09; bus.lookup_out_ready_i = 1'b1;
            end
            q.push_back(e_sweep("sweep0", i));
        end

        // Contended: W,W,W,W,R repeating; rvalid the cycle after each R.
        prev_r = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i % 5 < 4) q.push_back(e_w("burst_w", 4'b0010, 7'h05, prev_r));
            else           q.push_back(e_r("burst_r", 7'h09, prev_r));
            prev_r = (i % 5 == 4);
        end

        // Lookup only, out_ready toggling 1,0,1.
        tick(); bus.write_valid_i = 1'b0; bus.lookup_addr_i = 7'h11;
        q.push_back(e_r("lk_rdy1a", 7'h11, 1'b1));
        tick(); bus.lookup_out_ready_i = 1'b0; bus.lookup_addr_i = 7'h22;
        q.push_back(e_idle("lk_rdy0", 7'h22, 1'b1));
        tick(); bus.lookup_out_ready_i = 1'b1; bus.lookup_addr_i = 7'h33;
        q.push_back(e_r("lk_rdy1b", 7'h33, 1'b0));
        tick(); bus.lookup_valid_i = 1'b0; bus.lookup_addr_i = 7'h44;
        q.push_back(e_idle("idle", 7'h44, 1'b1));

        // Unopposed refills to way 2 / line 0x7F, then a lookup arrives.
        for (int j = 0; j < 6; j++) begin
            tick();
            bus.write_valid_i = 1'b1; bus.write_addr_i = 7'h7F; bus.write_way_i = 2'd2;
            q.push_back(e_w("wr_way2", 4'b0100, 7'h7F, 1'b0));
        end
        tick(); bus.lookup_valid_i = 1'b1; bus.lookup_addr_i = 7'h55;
        q.push_back(e_r("burst_sat", 7'h55, 1'b0));
        tick();
        q.push_back(e_w("after_r", 4'b0100, 7'h7F, 1'b1));

        // Flush together with a refill: refill still granted this cycle.
        tick(); bus.lookup_valid_i = 1'b0; bus.flush_valid_i = 1'b1;
        bus.write_addr_i = 7'h03; bus.write_way_i = 2'd3;
        q.push_back(e_w("flush_wr", 4'b1000, 7'h03, 1'b0));

        // Flush held through the sweep: not accepted until RUN.
        for (int i = 0; i < 128; i++) begin
            tick();
            if (i == 0) bus.write_valid_i = 1'b0;
            q.push_back(e_sweep("sweep1", i));
        end
        tick();
        q.push_back(e_idle("flush_run", 7'h55, 1'b0));

        // Second sweep, aborted by reset at line 60 and restarted.
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 0) bus.flush_valid_i = 1'b0;
            q.push_back(e_sweep("sweep2", i));
        end
        tick(); rst = 1'b1;
        q.push_back(e_rst("rst_mid"));
        for (int i = 0; i < 128; i++) begin
            tick();
            if (i == 0) rst = 1'b0;
            q.push_back(e_sweep("sweep3", i));
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            q.push_back(e_idle("run_end", 7'h55, 1'b0));
        end

        @(negedge clk);
`ifndef SNITCH_ICACHE_SCHED_PERF_EN
        chk("perf_wr", bus.perf_wr_stall_o, 32'd0);
        chk("perf_lk", bus.perf_lk_stall_o, 32'd0);
`endif
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d records left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
